// File: rtl/pipe_mem_pkg.sv
// Shared types and constants for the pipeline memory stage.
package pipe_mem_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  // Handshake FSM encoding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Fields carried from EX/MEM into MEM/WB.
  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic [REG_W-1:0]  wn;
    logic [DATA_W-1:0] alu;
  } wb_fields_t;

  // Control bits {wreg, m2reg} of a pipeline bubble.
  localparam logic [1:0] WB_BUBBLE_CTRL = 2'b00;

  // Memory port only addresses whole words.
  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] a);
    return {a[DATA_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipe_mem_if.sv
// Data-memory request/response port.
interface pipe_mem_if;
  import pipe_mem_pkg::*;

  logic              dm_req;
  logic              dm_we;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ready, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ready, dm_rdata
  );

endinterface

// File: rtl/pipe_mem_mem_wb_reg.sv
// MEM/WB pipeline register: loads new fields, or a bubble that clears
// only the control bits and keeps the data fields.
module mem_wb_reg
  import pipe_mem_pkg::*;
(
  input  logic              clk,
  input  logic              clrn,
  input  logic              bubble,
  input  wb_fields_t        d,
  input  logic              mdata_en,
  input  logic [DATA_W-1:0] mdata_d,
  output logic              wreg,
  output logic              m2reg,
  output logic [REG_W-1:0]  wn,
  output logic [DATA_W-1:0] alu,
  output logic [DATA_W-1:0] mdata
);

  // Pipeline register update with synchronous clear.
  always_ff @(posedge clk) begin
    if (clrn) begin
      wreg  <= 1'b0;
      m2reg <= 1'b0;
      wn    <= {REG_W{1'b0}};
      alu   <= {DATA_W{1'b0}};
      mdata <= {DATA_W{1'b0}};
    end else if (bubble) begin
      {wreg, m2reg} <= WB_BUBBLE_CTRL;
    end else begin
      wreg  <= d.wreg;
      m2reg <= d.m2reg;
      wn    <= d.wn;
      alu   <= d.alu;
      if (mdata_en) begin
        mdata <= mdata_d;
      end
    end
  end

endmodule

// File: rtl/pipe_mem.sv
// Memory stage: drives a variable-latency data memory through a small
// handshake FSM, stalls upstream while an access is outstanding and
// loads the MEM/WB register.
module pipe_mem
  import pipe_mem_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              MEMwreg,
  input  logic              MEMm2reg,
  input  logic              MEMwmem,
  input  logic [REG_W-1:0]  MEMwn,
  input  logic [DATA_W-1:0] MEMaluResult,
  input  logic [DATA_W-1:0] MEMdi,
  pipe_mem_if.master        dm,
  output logic              mem_stall,
  output logic              bus_err,
  output logic              WBwreg,
  output logic              WBm2reg,
  output logic [REG_W-1:0]  WBwn,
  output logic [DATA_W-1:0] WBaluResult,
  output logic [DATA_W-1:0] WBmemData
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  state_t            state_r;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic              bus_err_r;
  logic              lat_we_r;
  logic [DATA_W-1:0] lat_addr_r;
  logic [DATA_W-1:0] lat_wdata_r;
  wb_fields_t        lat_wb_r;

  logic              mem_instr_s;
  wb_fields_t        in_wb_s;
  logic              req_s;
  logic              we_s;
  logic [DATA_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;
  logic              stall_s;
  logic              bubble_s;
  wb_fields_t        wb_d_s;
  logic              mdata_en_s;
  logic              go_wait_s;
  logic              abort_s;

  // A store wins over a load when both controls are set; it never writes back.
  always_comb begin
    mem_instr_s   = MEMwmem | MEMm2reg;
    in_wb_s.wreg  = MEMwreg & ~(MEMwmem & MEMm2reg);
    in_wb_s.m2reg = MEMm2reg & ~MEMwmem;
    in_wb_s.wn    = MEMwn;
    in_wb_s.alu   = MEMaluResult;
  end

  // Request, stall and MEM/WB load decisions for the current cycle.
  always_comb begin
    req_s      = 1'b0;
    we_s       = lat_we_r;
    addr_s     = lat_addr_r;
    wdata_s    = lat_wdata_r;
    stall_s    = 1'b0;
    bubble_s   = 1'b1;
    wb_d_s     = in_wb_s;
    mdata_en_s = 1'b0;
    go_wait_s  = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_instr_s) begin
          req_s   = 1'b1;
          we_s    = MEMwmem;
          addr_s  = word_align(MEMaluResult);
          wdata_s = MEMdi;
          if (dm.dm_ready) begin
            bubble_s   = 1'b0;
            mdata_en_s = in_wb_s.m2reg;
          end else begin
            stall_s   = 1'b1;
            go_wait_s = 1'b1;
          end
        end else begin
          bubble_s = 1'b0;
        end
      end
      ST_WAIT: begin
        req_s  = 1'b1;
        wb_d_s = lat_wb_r;
        if (dm.dm_ready) begin
          bubble_s   = 1'b0;
          mdata_en_s = lat_wb_r.m2reg;
        end else if (wait_cnt_r == LIMIT) begin
          abort_s = 1'b1;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        bubble_s = 1'b1;
      end
    endcase
  end

  // Handshake FSM, wait counter, timeout flag and request latches.
  always_ff @(posedge clk) begin
    if (clrn) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= {CNT_W{1'b0}};
      bus_err_r   <= 1'b0;
      lat_we_r    <= 1'b0;
      lat_addr_r  <= {DATA_W{1'b0}};
      lat_wdata_r <= {DATA_W{1'b0}};
      lat_wb_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go_wait_s) begin
            state_r     <= ST_WAIT;
            wait_cnt_r  <= {{(CNT_W-1){1'b0}}, 1'b1};
            lat_we_r    <= MEMwmem;
            lat_addr_r  <= word_align(MEMaluResult);
            lat_wdata_r <= MEMdi;
            lat_wb_r    <= in_wb_s;
          end
        end
        ST_WAIT: begin
          if (dm.dm_ready) begin
            state_r <= ST_IDLE;
          end else if (abort_s) begin
            state_r   <= ST_IDLE;
            bus_err_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Reset overrides any in-flight request on the port.
  assign dm.dm_req   = req_s & ~clrn;
  assign dm.dm_we    = we_s;
  assign dm.dm_addr  = addr_s;
  assign dm.dm_wdata = wdata_s;
  assign mem_stall   = stall_s & ~clrn;
  assign bus_err     = bus_err_r;

  mem_wb_reg u_mem_wb (
    .clk      (clk),
    .clrn     (clrn),
    .bubble   (bubble_s),
    .d        (wb_d_s),
    .mdata_en (mdata_en_s),
    .mdata_d  (dm.dm_rdata),
    .wreg     (WBwreg),
    .m2reg    (WBm2reg),
    .wn       (WBwn),
    .alu      (WBaluResult),
    .mdata    (WBmemData)
  );

endmodule

// File: doc/pipe_mem.md
# pipe_mem

Memory stage of the five-stage pipeline. It sits directly downstream of the execute stage and consumes its EX/MEM register outputs: ALU result, store data, destination register and the wreg/m2reg/wmem controls. It drives a variable-latency data-memory port through a small handshake FSM and stalls the upstream stages while an access is outstanding. It then loads the MEM/WB pipeline register that feeds write-back.

## Interface
Parameters:
- WAIT_LIMIT, 16, maximum wait cycles for dm_ready before the access is aborted (range 1..255)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- clrn  in  1  reset, synchronous, active-high
- MEMwreg  in  1  instruction writes the register file
- MEMm2reg  in  1  instruction is a load
- MEMwmem  in  1  instruction is a store
- MEMwn  in  5  destination register number
- MEMaluResult  in  32  effective address, or the ALU result for non-memory instructions
- MEMdi  in  32  store data
- dm_req  out  1  memory request valid
- dm_we  out  1  1 = write, 0 = read
- dm_addr  out  32  word-aligned address ({MEMaluResult[31:2], 2'b00})
- dm_wdata  out  32  write data
- dm_ready  in  1  memory accepts the write, or read data is valid this cycle
- dm_rdata  in  32  read data, sampled only when dm_ready=1
- mem_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
- bus_err  out  1  sticky timeout flag
- WBwreg  out  1  registered write enable
- WBm2reg  out  1  registered write-back source select
- WBwn  out  5  registered destination register
- WBaluResult  out  32  registered ALU result
- WBmemData  out  32  registered load data

## Operation
- Memory instruction: MEMwmem | MEMm2reg. If both are 1, the instruction is a store, m2reg is ignored and WBwreg is forced to 0.
- FSM states:
  - IDLE:
    - Non-memory instruction: dm_req=0. The inputs pass into MEM/WB on the next edge.
    - Memory instruction: dm_req=1 combinationally, with dm_we=MEMwmem, dm_addr and dm_wdata taken from the inputs.
    - dm_ready=1 in the same cycle: zero-wait completion. MEM/WB captures the result (and dm_rdata for a load), mem_stall=0, state stays IDLE.
    - Otherwise: mem_stall=1, the request fields are latched into internal registers, state goes to WAIT, and wait_cnt is set to 1.
  - WAIT:
    - dm_req=1. The request fields come from the latched registers, not the inputs.
    - dm_ready=1: completion. MEM/WB captures the latched instruction plus dm_rdata, mem_stall=0, state goes to IDLE.
    - Otherwise, if wait_cnt==WAIT_LIMIT: abort. dm_req drops on the next edge, bus_err is set, MEM/WB receives a bubble, mem_stall=0, state goes to IDLE.
    - Otherwise: wait_cnt increments and mem_stall=1.
- A bubble in MEM/WB means WBwreg=0 and WBm2reg=0; the data fields hold their previous values.
- On every cycle with mem_stall=1, MEM/WB loads a bubble. Write-back never sees a duplicate.
- dm_ready while dm_req=0 is ignored.
- bus_err is cleared only by clrn.

## Timing
- Reset values (the edge where clrn=1):
  - state=IDLE, wait_cnt=0, bus_err=0.
  - All WB* outputs 0.
  - Latched request registers 0, so dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0.
  - mem_stall=0.
- Reset has priority over any in-flight access. The access is dropped with no WB update, and dm_req=0 from the cycle after reset onward.
- Latency:
  - Non-memory instruction: 1 cycle to the WB outputs.
  - Memory access: N+1 cycles, where N is the number of cycles dm_ready stayed low.
  - Stall cycles: N, with N ≤ WAIT_LIMIT.
- mem_stall is combinational from state, the inputs and dm_ready. dm_req, dm_we, dm_addr and dm_wdata are stable throughout WAIT.
- Handshake: a transfer occurs only on a cycle where dm_req & dm_ready. There is exactly one transfer per memory instruction.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE=1'b0, WAIT=1'b1).
  - Bubble constant.
  - Width constants: REG_W=5, DATA_W=32.
- Sub-module MEM_WB_reg: a plain enable/bubble register for the WB* fields, with synchronous active-high clrn. The FSM, wait counter and request latches stay in pipe_mem.

## Test plan
- Reset → all WB* outputs 0, dm_req=0, mem_stall=0, bus_err=0.
- ALU op: MEMwreg=1, MEMwn=5, MEMaluResult=0x1234 → next cycle WBwreg=1, WBwn=5, WBaluResult=0x1234, no dm_req.
- Load from 0x100, dm_ready tied high, dm_rdata=0xCAFEBABE → zero stall; next cycle WBmemData=0xCAFEBABE, WBm2reg=1.
- Store to 0x103, MEMdi=0xA5A5A5A5, dm_ready low for 3 cycles:
  - dm_addr=0x100 and dm_wdata stable for 4 cycles.
  - mem_stall high for exactly 3 cycles.
  - 3 bubbles, then WBwreg=0.
- Load with WAIT_LIMIT=4 and dm_ready never high → mem_stall high for 4 cycles, then bus_err=1, a bubble in WB, and state back to IDLE.
- clrn asserted during WAIT of a load → the next cycle shows dm_req=0 and WBwreg=0; a later dm_ready pulse is ignored.
